// File: rtl/hash_pkg.sv
// hash_pkg: block geometry, feeder FSM states and the 96-bit key block shared with the hash core.
package hash_pkg;
  localparam int BLOCK_BYTES = 12;
  typedef enum logic [1:0] {IDLE, FILL, PUSH} state_t;
  typedef struct packed {
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [3:0]  nbytes;
    logic        last;
  } blk_t;
endpackage

// File: rtl/hash_blk_slot.sv
// hash_blk_slot: one-entry output register with valid/ready; contents held until accepted.
module hash_blk_slot
  import hash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic ready,
  input  blk_t din,
  output logic valid,
  output blk_t dout
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) valid <= 1'b0;
endmodule

// File: rtl/hash_key_feeder.sv
// hash_key_feeder: packs a byte-serial key into little-endian 12-byte k0/k1/k2 blocks for the hash core.
module hash_key_feeder
  import hash_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] key_length,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [31:0]      k0,
  output logic [31:0]      k1,
  output logic [31:0]      k2,
  output logic [3:0]       blk_nbytes,
  output logic             blk_last,
  output logic [LEN_W-1:0] blk_key_length
);
  state_t           state;
  logic [95:0]      fbuf;
  logic [3:0]       fcnt, fcnt_n;
  logic [LEN_W-1:0] remaining, rem_n, key_len;
  logic             accept, push;
  blk_t             blk_in, blk_out;
  assign in_ready = state == FILL && fcnt < 4'(BLOCK_BYTES) && remaining != '0;
  assign accept   = in_valid && in_ready;
  assign fcnt_n   = fcnt + 4'(accept);
  assign rem_n    = remaining - LEN_W'(accept);
  assign push     = state == PUSH && (!blk_valid || blk_ready);
  assign busy     = state != IDLE || blk_valid;
  assign blk_in   = '{k0: fbuf[31:0], k1: fbuf[63:32], k2: fbuf[95:64], nbytes: fcnt, last: remaining == '0};
  // FILL leaves on the post-accept counts so the block is pushed the cycle after its final byte.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state     <= IDLE;
      fbuf      <= '0;
      fcnt      <= '0;
      remaining <= '0;
      key_len   <= '0;
    end else if (state == IDLE && start && !blk_valid) begin
      state     <= FILL;
      remaining <= key_length;
      key_len   <= key_length;
      fbuf      <= '0;
      fcnt      <= '0;
    end else if (state == FILL) begin
      if (accept) fbuf[{fcnt, 3'b000} +: 8] <= in_data;
      fcnt      <= fcnt_n;
      remaining <= rem_n;
      if (fcnt_n == 4'(BLOCK_BYTES) || rem_n == '0) state <= PUSH;
    end else if (push) begin
      fbuf  <= '0;
      fcnt  <= '0;
      state <= remaining == '0 ? IDLE : FILL;
    end
  hash_blk_slot u_slot (
    .clk  (CLK),
    .rst  (RST),
    .load (push),
    .ready(blk_ready),
    .din  (blk_in),
    .valid(blk_valid),
    .dout (blk_out)
  );
  assign k0             = blk_out.k0;
  assign k1             = blk_out.k1;
  assign k2             = blk_out.k2;
  assign blk_nbytes     = blk_out.nbytes;
  assign blk_last       = blk_out.last;
  assign blk_key_length = key_len;
endmodule

// File: tb/tb_hash_key_feeder.sv
// tb_hash_key_feeder: directed scenarios with hand-computed blocks for hash_key_feeder.
module tb_hash_key_feeder;
  import hash_pkg::*;
  logic        CLK = 1'b0, RST = 1'b1, start = 1'b0, in_valid = 1'b0, blk_ready = 1'b0;
  logic [7:0]  key_length = '0, in_data = '0, blk_key_length;
  logic        busy, in_ready, blk_valid, blk_last;
  logic [31:0] k0, k1, k2;
  logic [3:0]  blk_nbytes;
  int          errors = 0, checks = 0;
  logic [7:0]  keyb [256];
  blk_t        got [$];
  logic [7:0]  got_len [$];
  blk_t        cur;
  bit          unstable, seen_hold, rdy_at_hold;
  int          acc_at_hold;

  always #5 CLK = ~CLK;

  hash_key_feeder #(.LEN_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .key_length(key_length), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .k0(k0), .k1(k1), .k2(k2),
    .blk_nbytes(blk_nbytes), .blk_last(blk_last), .blk_key_length(blk_key_length)
  );

  assign cur = '{k0: k0, k1: k1, k2: k2, nbytes: blk_nbytes, last: blk_last};

  // Drives one key from keyb and collects every accepted block; blk_ready held low for the first hold cycles.
  task automatic run_key(input int len, input int hold);
    int idx, cyc;
    bit done, have;
    blk_t snap;
    got.delete(); got_len.delete();
    unstable = 0; seen_hold = 0; acc_at_hold = -1; rdy_at_hold = 1;
    @(negedge CLK); start = 1; key_length = 8'(len);
    @(negedge CLK); start = 0;
    idx = 0; cyc = 0; done = 0; have = 0;
    while (!done && cyc < 3000) begin
      in_valid  = idx < len;
      in_data   = idx < len ? keyb[idx] : 8'h00;
      blk_ready = cyc >= hold;
      #1;
      if (cyc == hold - 1) begin acc_at_hold = idx; rdy_at_hold = in_ready; end
      if (blk_valid && !blk_ready) begin
        seen_hold = 1;
        if (!have) begin snap = cur; have = 1; end
        else if (cur !== snap) unstable = 1;
      end
      if (in_valid && in_ready) idx++;
      if (blk_valid && blk_ready) begin
        got.push_back(cur);
        got_len.push_back(blk_key_length);
        done = blk_last;
      end
      cyc++;
      @(negedge CLK);
    end
    in_valid = 0; blk_ready = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_key_timeout: len=%0d last block never seen after %0d cycles", len, cyc);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid: got %b want 0", blk_valid); end
    checks++; if ({k0, k1, k2} !== 96'h0) begin errors++; $display("FAIL reset_k: got %h want 0", {k0, k1, k2}); end
    checks++; if ({blk_nbytes, blk_last, blk_key_length} !== 13'h0) begin errors++; $display("FAIL reset_meta: got %h want 0", {blk_nbytes, blk_last, blk_key_length}); end
    RST = 0;
    @(negedge CLK);
    checks++; if ({busy, in_ready} !== 2'b00) begin errors++; $display("FAIL reset_idle: busy/in_ready got %b want 00", {busy, in_ready}); end
  endtask

  task automatic test_short;
    for (int i = 0; i < 3; i++) keyb[i] = 8'h61 + 8'(i);
    run_key(3, 0);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL short_count: got %0d want 1", got.size()); end
    else begin
      checks++; if (got[0].k0 !== 32'h00636261) begin errors++; $display("FAIL short_k0: got %h want 00636261", got[0].k0); end
      checks++; if ({got[0].k1, got[0].k2} !== 64'h0) begin errors++; $display("FAIL short_k12: got %h want 0", {got[0].k1, got[0].k2}); end
      checks++; if (got[0].nbytes !== 4'd3 || got[0].last !== 1'b1) begin errors++; $display("FAIL short_meta: nbytes/last got %0d/%b want 3/1", got[0].nbytes, got[0].last); end
      checks++; if (got_len[0] !== 8'd3) begin errors++; $display("FAIL short_klen: got %0d want 3", got_len[0]); end
    end
  endtask

  task automatic test_exact;
    for (int i = 0; i < 12; i++) keyb[i] = 8'h61 + 8'(i);
    run_key(12, 0);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL exact_count: got %0d want 1", got.size()); end
    else begin
      checks++; if ({got[0].k0, got[0].k1, got[0].k2} !== 96'h64636261_68676665_6c6b6a69) begin errors++; $display("FAIL exact_k: got %h want 646362616867666 56c6b6a69", {got[0].k0, got[0].k1, got[0].k2}); end
      checks++; if (got[0].nbytes !== 4'd12 || got[0].last !== 1'b1) begin errors++; $display("FAIL exact_meta: nbytes/last got %0d/%b want 12/1", got[0].nbytes, got[0].last); end
    end
    in_valid = 1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL exact_in_ready_after: got %b want 0", in_ready); end
    in_valid = 0;
  endtask

  task automatic test_full_partial;
    for (int i = 0; i < 15; i++) keyb[i] = 8'h61 + 8'(i);
    run_key(15, 0);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL fp_count: got %0d want 2", got.size()); end
    else begin
      checks++; if (got[0].k2 !== 32'h6c6b6a69 || got[0].nbytes !== 4'd12 || got[0].last !== 1'b0) begin errors++; $display("FAIL fp_blk1: k2/nbytes/last got %h/%0d/%b want 6c6b6a69/12/0", got[0].k2, got[0].nbytes, got[0].last); end
      checks++; if ({got[1].k0, got[1].k1, got[1].k2} !== {32'h006f6e6d, 64'h0}) begin errors++; $display("FAIL fp_blk2_k: got %h want 006f6e6d0000000000000000", {got[1].k0, got[1].k1, got[1].k2}); end
      checks++; if (got[1].nbytes !== 4'd3 || got[1].last !== 1'b1) begin errors++; $display("FAIL fp_blk2_meta: nbytes/last got %0d/%b want 3/1", got[1].nbytes, got[1].last); end
    end
  endtask

  task automatic test_zero;
    run_key(0, 0);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL zero_count: got %0d want 1", got.size()); end
    else begin
      checks++; if (got[0] !== '{k0: 32'h0, k1: 32'h0, k2: 32'h0, nbytes: 4'd0, last: 1'b1}) begin errors++; $display("FAIL zero_blk: got %h want all-zero with last=1", got[0]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int pos, bad, nb;
    logic [95:0] w;
    for (int i = 0; i < 250; i++) keyb[i] = 8'(i * 7 + 3);
    run_key(250, 40);
    checks++; if (acc_at_hold !== 24) begin errors++; $display("FAIL bp_buffered: got %0d bytes want 24", acc_at_hold); end
    checks++; if (rdy_at_hold !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", rdy_at_hold); end
    checks++; if ({seen_hold, unstable} !== 2'b10) begin errors++; $display("FAIL bp_hold_stable: seen/unstable got %b%b want 10", seen_hold, unstable); end
    checks++; if (got.size() !== 21) begin errors++; $display("FAIL bp_count: got %0d want 21", got.size()); end
    else begin
      checks++; if (got[20].nbytes !== 4'd10 || got[20].last !== 1'b1) begin errors++; $display("FAIL bp_last: nbytes/last got %0d/%b want 10/1", got[20].nbytes, got[20].last); end
    end
    pos = 0; bad = 0;
    foreach (got[b]) begin
      w  = {got[b].k2, got[b].k1, got[b].k0};
      nb = int'(got[b].nbytes);
      for (int j = 0; j < nb; j++) begin
        if (pos >= 250 || w[8*j +: 8] !== keyb[pos]) bad++;
        pos++;
      end
    end
    checks++; if (bad !== 0 || pos !== 250) begin errors++; $display("FAIL bp_bytes: %0d wrong of %0d, want 0 wrong of 250", bad, pos); end
  endtask

  task automatic test_reset_mid;
    int idx, cyc;
    for (int i = 0; i < 100; i++) keyb[i] = 8'(i + 1);
    @(negedge CLK); start = 1; key_length = 8'd100;
    @(negedge CLK); start = 0;
    idx = 0; cyc = 0; blk_ready = 1;
    while (idx < 30 && cyc < 200) begin
      in_valid = 1; in_data = keyb[idx];
      #1;
      if (in_ready) idx++;
      cyc++;
      @(negedge CLK);
    end
    in_valid = 0; blk_ready = 0;
    checks++; if (busy !== 1'b1 || blk_key_length !== 8'd100) begin errors++; $display("FAIL midrst_pre: busy/klen got %b/%0d want 1/100", busy, blk_key_length); end
    #1 RST = 1;
    #1;
    checks++; if ({busy, in_ready, blk_valid, blk_last} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl: busy/in_ready/valid/last got %b want 0000", {busy, in_ready, blk_valid, blk_last}); end
    checks++; if ({k0, k1, k2, blk_nbytes, blk_key_length} !== 108'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", {k0, k1, k2, blk_nbytes, blk_key_length}); end
    @(negedge CLK); RST = 0;
    for (int i = 0; i < 3; i++) keyb[i] = 8'h61 + 8'(i);
    run_key(3, 0);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL midrst_after_count: got %0d want 1", got.size()); end
    else begin
      checks++; if (got[0] !== '{k0: 32'h00636261, k1: 32'h0, k2: 32'h0, nbytes: 4'd3, last: 1'b1}) begin errors++; $display("FAIL midrst_after_blk: got %h want 00636261 0 0 n=3 last=1", got[0]); end
    end
  endtask

  initial begin
    test_reset;
    test_short;
    test_exact;
    test_full_partial;
    test_zero;
    test_backpressure;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hash_key_feeder.md
# hash_key_feeder

Packs a byte-serial key into the 96-bit (k0/k1/k2) blocks consumed by the Jenkins `hash` core. It works from the key length given at start, emits blocks with a valid/ready handshake, and marks the final, possibly partial, block. It sits between the key source (parser or DMA byte stream) and the hash core's `key_length`/`k0..k2` inputs, replacing the bench-side key slicer.

## Interface
- `LEN_W`, 8: width of key length and byte counters (keys up to 255 bytes).
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse: begin a key; ignored while `busy`.
- `key_length`  in  LEN_W  key length in bytes, sampled with `start`.
- `busy`  out  1  key in progress or block still held on the output.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  feeder accepts a byte this cycle.
- `in_data`  in  8  key byte, in key order.
- `blk_valid`  out  1  output block valid.
- `blk_ready`  in  1  hash core accepts the block.
- `k0`, `k1`, `k2`  out  32 each  block words.
- `blk_nbytes`  out  4  valid bytes in the block (0..12).
- `blk_last`  out  1  final block of the key.
- `blk_key_length`  out  LEN_W  latched total key length.

## Operation
- **Reset values:** every output is 0; state IDLE; fill buffer and output slot empty.
- **FSM states**
  - IDLE: `start` latches the length into `remaining` and clears the fill buffer, then goes to FILL.
  - FILL: `in_ready` = (`fcnt` < 12) && (`remaining` > 0). Each accepted byte (`in_valid` && `in_ready`) decrements `remaining` and increments `fcnt`.
  - FILL → PUSH when `fcnt` == 12, or when `remaining` == 0.
  - PUSH: transfer the fill buffer to the output slot when the slot is free (!`blk_valid` || `blk_ready`), and clear the fill buffer. Then:
    - if `remaining` == 0, set `blk_last` and go to IDLE;
    - otherwise return to FILL.
- **Byte packing:** block byte i (0..11) goes to k[i/4], bits [8*(i%4)+7 : 8*(i%4)]. This is little-endian, matching lookup3. Unfilled bytes are 0.
- **Zero-length key:** emits one block with all words 0, `blk_nbytes`=0, `blk_last`=1.
- **Output hold:** while `blk_valid` && !`blk_ready`, all `blk_*`/`k*` outputs are held stable. The fill buffer may keep filling up to 12 bytes, then `in_ready` drops.
- **`busy`** = (state != IDLE) || `blk_valid`.
- **Excess input:** bytes beyond `key_length` are never accepted, because `in_ready` is 0 outside FILL.
- **Reset mid-key:** the key is discarded; no partial block is emitted.

## Timing
- **Input rate:** one byte per cycle at most. `in_ready` is a registered-state function and does not depend combinationally on `in_valid`.
- **Block latency:** 12th (or final) byte accepted at edge N → PUSH during the following cycle → `blk_valid` high after edge N+1 (slot free). Sustained rate is 12 bytes per 13 cycles.
- **Start latency:** `start` at edge S → `in_ready` can be high after edge S (key_length > 0).
- **Buffer capacity:** maximum buffered data is 24 bytes (fill buffer + output slot) under backpressure.
- **Output handshake:** `blk_valid` falls after the accepting edge unless a new block is transferred on that same edge.

## Structure
- **Shared package `hash_pkg`:**
  - `BLOCK_BYTES` = 12 and the FSM state enum (IDLE/FILL/PUSH);
  - a block struct {k0, k1, k2, nbytes, last}. The hash core and future bench models use the same struct.
- **Sub-module `hash_blk_slot`:** the one-entry output register with valid/ready. All other logic is flat.

## Test plan
- **Short key:** len 3, bytes 61 62 63 → one block: `k0`=0x00636261, `k1`=`k2`=0, `blk_nbytes`=3, `blk_last`=1, `blk_key_length`=3.
- **Exact block:** len 12 "abcdefghijkl" → `k0`=0x64636261, `k1`=0x68676665, `k2`=0x6c6b6a69, `blk_nbytes`=12, `blk_last`=1; `in_ready` low afterward.
- **Full + partial:** len 15 → block 1 as above with `blk_last`=0, then `k0`=0x006f6e6d, `blk_nbytes`=3, `blk_last`=1.
- **Zero length:** `start` with len 0 → one all-zero block, `blk_nbytes`=0, `blk_last`=1; `busy` low the cycle after acceptance.
- **Backpressure:** len 250, `blk_ready` held low for 40 cycles → `in_ready` drops after 24 bytes and outputs stay stable. After release: 21 blocks, the last with `blk_nbytes`=10; the byte sequence matches the input exactly.
- **Reset mid-key:** `RST` after 30 bytes of a len 100 key → all outputs 0 immediately. A following len 3 key then produces the correct single block.
